stopwatch_hms: RTL and testbench
================================

Name: stopwatch_hms

Overview:
- Parametrised successor of the 4-digit stopwatch/7-segment driver.
- Holds a full HH:MM:SS BCD time chain that counts up, or down as a countdown timer with a done/alarm indication.
- Start/stop and clear buttons are debounced and edge-detected.
- Drives a multiplexed common 7-segment display of 4 or 6 digits; segments and digit select are updated in the same cycle.

Parameters:
- TICK_DIV, 1000000: clk0 cycles per counted second.
- SCAN_DIV, 262144: clk0 cycles per display digit slot.
- DEB_CYCLES, 65536: cycles a synchronised button level must hold stable before it is accepted.
- NUM_DIGITS, 4: displayed digits; legal values 4 or 6.

Ports:
- clk0  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- btn_run  in  1  raw start/stop button, active-high, asynchronous.
- btn_clr  in  1  raw clear button, active-high, asynchronous.
- btn_lap  in  1  raw lap button; used only with LAP_EN.
- dir  in  1  0 = count up, 1 = count down.
- win_sel  in  1  NUM_DIGITS=4 only: 0 shows MM:SS, 1 shows HH:MM.
- preset_bcd  in  24  countdown start value {h10,h1,m10,m1,s10,s1}, 4 bits each.
- seg7  out  8  {dp,g,f,e,d,c,b,a}, active-high.
- line  out  NUM_DIGITS  one-hot digit enable; bit 0 is the rightmost digit.
- time_bcd  out  24  live counter value, same packing as preset_bcd.
- running  out  1  1 while counting.
- done  out  1  one-cycle pulse when a countdown reaches zero.
- alarm  out  1  latched countdown-expired flag.

Behaviour:
- Reset (rst_n=0 at a clk0 edge):
  - time_bcd = 0, running = 0, done = 0, alarm = 0.
  - Prescaler, scan counter, digit index and debouncers cleared.
  - seg7 = 8'h00, line = 1 (digit 0 selected).
  - Reset mid-count abandons the count; there is no partial tick.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a stability counter.
  - The debounced level changes only after DEB_CYCLES consecutive equal samples.
  - A press is a one-cycle pulse on the debounced rising edge.
  - Latency from raw edge to press pulse is 2+DEB_CYCLES cycles, ±1.
- Run control:
  - A run press toggles running.
  - A clear press forces running=0 and clears the prescaler. It loads time_bcd with preset_bcd if dir=1, or 0 if dir=0, and clears alarm.
  - Clear and run presses in the same cycle: clear wins.
  - A run press with dir=1 and time_bcd=0 leaves running=0.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1 only while running=1 and holds while stopped, so a resumed count keeps its fractional second.
  - tick = prescaler==TICK_DIV-1 && running.
- Up count, on tick:
  - s1 0-9, s10 0-5, m1 0-9, m10 0-5.
  - h1 0-9, except 0-3 when h10=2; h10 0-2.
  - 23:59:59 wraps to 00:00:00 and keeps running.
- Down count, on tick:
  - Mirror borrow chain. 00:00:00 is never decremented.
  - A tick that takes the value to 00:00:00 sets running=0, pulses done for 1 cycle and sets alarm; alarm holds until clear or reset.
  - Out-of-range preset digits load as-is; each digit wraps at its own limit on the next borrow, with no correction.
- dir may change at any time and takes effect on the next tick.
- Display:
  - Scan counter 0..SCAN_DIV-1; at its wrap the digit index advances 0..NUM_DIGITS-1, then wraps to 0.
  - line and seg7 are registered together from the same index, so there is no ghosting.
  - Window: NUM_DIGITS=6 shows s1,s10,m1,m10,h1,h10 on digits 0-5. NUM_DIGITS=4 shows the low or high four digits of that list per win_sel.
  - Decode 0-9 uses the standard 7-seg patterns; values 10-15 are blank.
  - dp is lit on window digit 2, and also on digit 4 when NUM_DIGITS=6.
  - While alarm=1, segments blank during the second half of each TICK_DIV period; line keeps scanning.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: btn_lap is debounced like the other buttons.
  - A press while running latches the current value into a lap register; the display shows the lap register while time_bcd keeps counting.
  - A second lap press returns the display to live.
  - A clear press, or running going to 0, also returns the display to live.
- Undefined: btn_lap is ignored, no lap register is built, and the display always shows live time.

Test Plan:
- Bench parameters: TICK_DIV=4, SCAN_DIV=2, DEB_CYCLES=3, NUM_DIGITS=6.
- Reset: rst_n low 2 cycles -> time_bcd=0, running=0, line=1, seg7=0. Run press -> running=1 at 2+DEB_CYCLES(±1) cycles; s1=1 after 4 further cycles.
- Debounce: btn_run glitch high for 2 cycles -> no press and running unchanged. High for 10 cycles -> exactly one toggle.
- Wrap: preload 23:59:59 up, run, 1 tick -> 00:00:00 and running stays 1. From 09:59:59 -> 10:00:00. From 19:59:59 -> 20:00:00.
- Countdown: dir=1, preset 00:00:02, clear, run -> 00:00:01, then 00:00:00 with done high 1 cycle, alarm=1, running=0. Run press -> running stays 0. Clear -> alarm=0.
- Scan: line steps 1,2,4,8,16,32,1 every 2 cycles. At line=4, seg7 carries the m1 pattern with dp=1. At line=16, dp=1.
- Clear+run in the same cycle -> running=0 and value loaded. With STOPWATCH_LAP_EN: lap at 00:00:05 -> display frozen at 5 while time_bcd reaches 8; lap again -> display shows live time.

Source files
------------

// File: rtl/stopwatch_hms_if.sv
// Signal bundle between the stopwatch_hms core and its surroundings:
// raw buttons, mode controls, preset value, display drive and status.
interface stopwatch_hms_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  btn_run;
    logic                  btn_clr;
    logic                  btn_lap;
    logic                  dir;
    logic                  win_sel;
    logic [23:0]           preset_bcd;
    logic [7:0]            seg7;
    logic [NUM_DIGITS-1:0] line;
    logic [23:0]           time_bcd;
    logic                  running;
    logic                  done;
    logic                  alarm;

    modport master (
        output btn_run, btn_clr, btn_lap, dir, win_sel, preset_bcd,
        input  seg7, line, time_bcd, running, done, alarm
    );

    modport slave (
        input  btn_run, btn_clr, btn_lap, dir, win_sel, preset_bcd,
        output seg7, line, time_bcd, running, done, alarm
    );
endinterface

// File: rtl/stopwatch_hms.sv
// HH:MM:SS BCD stopwatch / countdown timer with debounced buttons and a
// multiplexed 7-segment driver. Optional lap hold: define STOPWATCH_LAP_EN.
module stopwatch_hms #(
    parameter int TICK_DIV   = 1000000,
    parameter int SCAN_DIV   = 262144,
    parameter int DEB_CYCLES = 65536,
    parameter int NUM_DIGITS = 4
) (
    input logic            clk0,
    input logic            rst_n,
    stopwatch_hms_if.slave sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES) + 1;
`ifdef STOPWATCH_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic [NB-1:0] btn_raw, sync0, sync1, level, level_d, press;
    logic [DW-1:0] deb_cnt [NB];

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {sw.btn_lap, sw.btn_clr, sw.btn_run};
`else
    logic unused_lap;
    assign unused_lap = sw.btn_lap;
    assign btn_raw    = {sw.btn_clr, sw.btn_run};
`endif

    // Level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            sync0   <= '0;
            sync1   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync0   <= btn_raw;
            sync1   <= sync0;
            level_d <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync1[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    level[i]   <= sync1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_d;

    logic [23:0]   time_q, up_next, dn_next, disp_bcd;
    logic [PW-1:0] presc, blink_cnt;
    logic          running_q, done_q, alarm_q, tick;
    logic [3:0]    s1, s10, m1, m10, h1, h10;

    assign {h10, h1, m10, m1, s10, s1} = time_q;
    assign tick = running_q && (presc == PW'(TICK_DIV - 1));

    always_comb begin
        up_next = time_q;
        if (s1 != 4'd9) up_next[3:0] = s1 + 4'd1;
        else begin
            up_next[3:0] = 4'd0;
            if (s10 != 4'd5) up_next[7:4] = s10 + 4'd1;
            else begin
                up_next[7:4] = 4'd0;
                if (m1 != 4'd9) up_next[11:8] = m1 + 4'd1;
                else begin
                    up_next[11:8] = 4'd0;
                    if (m10 != 4'd5) up_next[15:12] = m10 + 4'd1;
                    else begin
                        up_next[15:12] = 4'd0;
                        if (h1 != ((h10 == 4'd2) ? 4'd3 : 4'd9)) up_next[19:16] = h1 + 4'd1;
                        else begin
                            up_next[19:16] = 4'd0;
                            up_next[23:20] = (h10 == 4'd2) ? 4'd0 : h10 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Borrow chain; digits are decremented as loaded, without range correction.
    always_comb begin
        dn_next = time_q;
        if (s1 != 4'd0) dn_next[3:0] = s1 - 4'd1;
        else begin
            dn_next[3:0] = 4'd9;
            if (s10 != 4'd0) dn_next[7:4] = s10 - 4'd1;
            else begin
                dn_next[7:4] = 4'd5;
                if (m1 != 4'd0) dn_next[11:8] = m1 - 4'd1;
                else begin
                    dn_next[11:8] = 4'd9;
                    if (m10 != 4'd0) dn_next[15:12] = m10 - 4'd1;
                    else begin
                        dn_next[15:12] = 4'd5;
                        if (h1 != 4'd0) dn_next[19:16] = h1 - 4'd1;
                        else begin
                            dn_next[19:16] = 4'd9;
                            dn_next[23:20] = (h10 != 4'd0) ? h10 - 4'd1 : 4'd2;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            time_q    <= '0;
            presc     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (press[1]) begin
                running_q <= 1'b0;
                presc     <= '0;
                time_q    <= sw.dir ? sw.preset_bcd : 24'd0;
                alarm_q   <= 1'b0;
            end else begin
                if (running_q) presc <= tick ? '0 : presc + 1'b1;
                if (press[0]) running_q <= running_q ? 1'b0 : !(sw.dir && time_q == 24'd0);
                if (tick) begin
                    if (!sw.dir) begin
                        time_q <= up_next;
                    end else if (time_q != 24'd0) begin
                        time_q <= dn_next;
                        if (dn_next == 24'd0) begin
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            alarm_q   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_active;
    logic [23:0] lap_q;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            lap_active <= 1'b0;
            lap_q      <= '0;
        end else if (press[1] || !running_q) begin
            lap_active <= 1'b0;
        end else if (press[2]) begin
            lap_active <= !lap_active;
            if (!lap_active) lap_q <= time_q;
        end
    end

    assign disp_bcd = lap_active ? lap_q : time_q;
`else
    assign disp_bcd = time_q;
`endif

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    logic [SW-1:0]         scan_cnt;
    logic [2:0]            idx, src_idx;
    logic [3:0]            nib;
    logic                  dp, blank;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] line_q;

    assign src_idx = idx + (((NUM_DIGITS == 4) && sw.win_sel) ? 3'd2 : 3'd0);
    assign nib     = disp_bcd[{src_idx, 2'b00} +: 4];
    assign dp      = (idx == 3'd2) || ((NUM_DIGITS == 6) && (idx == 3'd4));
    // Blink phase runs freely so the alarm flashes even with the prescaler held.
    assign blank   = alarm_q && (blink_cnt >= PW'(TICK_DIV / 2));

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            seg_q     <= 8'h00;
            line_q    <= NUM_DIGITS'(1);
        end else begin
            blink_cnt <= (blink_cnt == PW'(TICK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            line_q <= NUM_DIGITS'(1) << idx;
            seg_q  <= blank ? 8'h00 : {dp, dec7(nib)};
        end
    end

    assign sw.seg7     = seg_q;
    assign sw.line     = line_q;
    assign sw.time_bcd = time_q;
    assign sw.running  = running_q;
    assign sw.done     = done_q;
    assign sw.alarm    = alarm_q;
endmodule

// File: tb/tb_stopwatch_hms.sv
// Self-checking bench for stopwatch_hms with small dividers and six digits.
module tb_stopwatch_hms;
    localparam int ND = 6;

    logic clk0  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk0 = ~clk0;

    stopwatch_hms_if #(.NUM_DIGITS(ND)) swi ();

    stopwatch_hms #(
        .TICK_DIV(4), .SCAN_DIV(2), .DEB_CYCLES(3), .NUM_DIGITS(ND)
    ) dut (
        .clk0(clk0),
        .rst_n(rst_n),
        .sw(swi.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
            4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
            4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  default: p = 7'h00;
        endcase
        return {dp, p};
    endfunction

    // which: 0 run, 1 clear, 2 lap, 3 run+clear together
    task automatic press_btn(input int which);
        repeat (6) @(negedge clk0);
        if (which == 0 || which == 3) swi.btn_run = 1'b1;
        if (which == 1 || which == 3) swi.btn_clr = 1'b1;
        if (which == 2) swi.btn_lap = 1'b1;
        repeat (8) @(negedge clk0);
        swi.btn_run = 1'b0;
        swi.btn_clr = 1'b0;
        swi.btn_lap = 1'b0;
    endtask

    task automatic load_value(input logic [23:0] v);
        swi.dir        = 1'b1;
        swi.preset_bcd = v;
        press_btn(1);
        vectors++;
        if (swi.time_bcd !== v || swi.running !== 1'b0) begin
            miscompares++;
            $display("FAIL load: time %h running %b, want %h running 0", swi.time_bcd, swi.running, v);
        end
    endtask

    task automatic test_reset();
        int k;
        logic [23:0] e;
        swi.btn_run = 0; swi.btn_clr = 0; swi.btn_lap = 0;
        swi.dir = 0; swi.win_sel = 0; swi.preset_bcd = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk0);
        vectors++;
        if (swi.time_bcd !== 24'd0) begin miscompares++; $display("FAIL reset_time: got %h want 000000", swi.time_bcd); end
        vectors++;
        if (swi.running !== 1'b0 || swi.done !== 1'b0 || swi.alarm !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: run/done/alarm %b%b%b want 000", swi.running, swi.done, swi.alarm);
        end
        vectors++;
        if (swi.line !== 6'd1) begin miscompares++; $display("FAIL reset_line: got %b want 000001", swi.line); end
        vectors++;
        if (swi.seg7 !== 8'h00) begin miscompares++; $display("FAIL reset_seg7: got %h want 00", swi.seg7); end
        rst_n = 1'b1;
        swi.btn_run = 1'b1;
        k = 0;
        while (swi.running !== 1'b1 && k < 12) begin @(posedge clk0); #1; k++; end
        vectors++;
        if (k < 4 || k > 6) begin miscompares++; $display("FAIL run_latency: got %0d cycles want 4..6", k); end
        sb_q.push_back(32'h000000); sb_q.push_back(32'h000000);
        sb_q.push_back(32'h000000); sb_q.push_back(32'h000001);
        while (sb_q.size() > 0) begin
            @(posedge clk0); #1;
            e = sb_q.pop_front();
            vectors++;
            if (swi.time_bcd !== e) begin miscompares++; $display("FAIL first_tick: got %h want %h", swi.time_bcd, e); end
        end
        @(negedge clk0);
        swi.btn_run = 1'b0;
    endtask

    task automatic test_debounce();
        int toggles;
        logic prev;
        swi.dir = 1'b0;
        press_btn(1);
        repeat (8) @(negedge clk0);
        swi.btn_run = 1'b1;
        repeat (2) @(negedge clk0);
        swi.btn_run = 1'b0;
        toggles = 0; prev = swi.running;
        repeat (15) begin
            @(negedge clk0);
            if (swi.running !== prev) toggles++;
            prev = swi.running;
        end
        vectors++;
        if (toggles != 0 || swi.running !== 1'b0) begin
            miscompares++; $display("FAIL glitch: toggles %0d running %b want 0 and 0", toggles, swi.running);
        end
        swi.btn_run = 1'b1;
        toggles = 0; prev = swi.running;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) swi.btn_run = 1'b0;
            @(negedge clk0);
            if (swi.running !== prev) toggles++;
            prev = swi.running;
        end
        vectors++;
        if (toggles != 1) begin miscompares++; $display("FAIL long_press: toggles %0d want 1", toggles); end
        vectors++;
        if (swi.running !== 1'b1) begin miscompares++; $display("FAIL long_press_run: got %b want 1", swi.running); end
    endtask

    task automatic test_wrap();
        logic [23:0] start_v [3] = '{24'h235959, 24'h095959, 24'h195959};
        logic [23:0] prev, e;
        int n;
        for (int c = 0; c < 3; c++) begin
            load_value(start_v[c]);
            swi.dir = 1'b0;
            if (c == 0) begin sb_q.push_back(32'h000000); sb_q.push_back(32'h000001); end
            if (c == 1) sb_q.push_back(32'h100000);
            if (c == 2) sb_q.push_back(32'h200000);
            fork
                press_btn(0);
                while (sb_q.size() > 0) begin
                    prev = swi.time_bcd; n = 0;
                    while (swi.time_bcd === prev && n < 60) begin @(negedge clk0); n++; end
                    e = sb_q.pop_front();
                    vectors++;
                    if (swi.time_bcd !== e) begin miscompares++; $display("FAIL wrap: got %h want %h", swi.time_bcd, e); end
                end
            join
            if (c == 0) begin
                vectors++;
                if (swi.running !== 1'b1) begin miscompares++; $display("FAIL wrap_running: got %b want 1", swi.running); end
            end
        end
    endtask

    task automatic test_countdown();
        logic [23:0] prev, e;
        int n, done_cnt, blank_cnt;
        load_value(24'h000002);
        sb_q.push_back(32'h000001);
        fork
            press_btn(0);
            while (sb_q.size() > 0) begin
                prev = swi.time_bcd; n = 0;
                while (swi.time_bcd === prev && n < 60) begin @(negedge clk0); n++; end
                e = sb_q.pop_front();
                vectors++;
                if (swi.time_bcd !== e) begin miscompares++; $display("FAIL countdown: got %h want %h", swi.time_bcd, e); end
            end
        join
        done_cnt = 0;
        repeat (12) begin @(negedge clk0); if (swi.done === 1'b1) done_cnt++; end
        vectors++;
        if (swi.time_bcd !== 24'd0) begin miscompares++; $display("FAIL countdown_zero: got %h want 000000", swi.time_bcd); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL done_pulse: got %0d cycles want 1", done_cnt); end
        vectors++;
        if (swi.alarm !== 1'b1 || swi.running !== 1'b0) begin
            miscompares++; $display("FAIL expire_flags: alarm %b running %b want 1 0", swi.alarm, swi.running);
        end
        blank_cnt = 0;
        repeat (8) begin @(negedge clk0); if (swi.seg7 === 8'h00) blank_cnt++; end
        vectors++;
        if (blank_cnt != 4) begin miscompares++; $display("FAIL alarm_blink: blank %0d of 8 want 4", blank_cnt); end
        press_btn(0);
        repeat (4) @(negedge clk0);
        vectors++;
        if (swi.running !== 1'b0) begin miscompares++; $display("FAIL run_at_zero: got %b want 0", swi.running); end
        press_btn(1);
        vectors++;
        if (swi.alarm !== 1'b0 || swi.time_bcd !== 24'h000002) begin
            miscompares++; $display("FAIL clear_alarm: alarm %b time %h want 0 000002", swi.alarm, swi.time_bcd);
        end
    endtask

    task automatic test_scan();
        logic [3:0] d [6] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        logic [5:0] l;
        logic [31:0] e;
        int n, j;
        load_value(24'h123456);
        n = 0;
        while (swi.line !== 6'd32 && n < 40) begin @(negedge clk0); n++; end
        while (swi.line !== 6'd1 && n < 80) begin @(negedge clk0); n++; end
        for (int i = 0; i < 7; i++) begin
            j = i % 6;
            l = 6'd1 << j;
            sb_q.push_back({18'd0, l, seg_of(d[j], (j == 2) || (j == 4))});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if ({swi.line, swi.seg7} !== e[13:0]) begin
                miscompares++; $display("FAIL scan: line %b seg %h want line %b seg %h", swi.line, swi.seg7, e[13:8], e[7:0]);
            end
            repeat (2) @(negedge clk0);
        end
    endtask

    task automatic test_clr_run();
        logic ever_run;
        swi.dir = 1'b1;
        swi.preset_bcd = 24'h000042;
        ever_run = 1'b0;
        fork
            press_btn(3);
            repeat (30) begin @(negedge clk0); if (swi.running === 1'b1) ever_run = 1'b1; end
        join
        vectors++;
        if (ever_run !== 1'b0 || swi.time_bcd !== 24'h000042) begin
            miscompares++; $display("FAIL clr_run: ran %b time %h want 0 000042", ever_run, swi.time_bcd);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        int n;
        swi.dir = 1'b0;
        press_btn(1);
        press_btn(0);
        n = 0;
        while (swi.time_bcd !== 24'h000004 && n < 80) begin @(negedge clk0); n++; end
        swi.btn_lap = 1'b1;
        repeat (8) @(negedge clk0);
        swi.btn_lap = 1'b0;
        while (swi.time_bcd !== 24'h000008 && n < 160) begin @(negedge clk0); n++; end
        vectors++;
        if (swi.time_bcd !== 24'h000008) begin miscompares++; $display("FAIL lap_count: got %h want 000008", swi.time_bcd); end
        while (swi.line !== 6'd1 && n < 200) begin @(negedge clk0); n++; end
        vectors++;
        if (swi.seg7 !== seg_of(4'd5, 1'b0)) begin miscompares++; $display("FAIL lap_frozen_s1: got %h want %h", swi.seg7, seg_of(4'd5, 1'b0)); end
        while (swi.line !== 6'd2 && n < 220) begin @(negedge clk0); n++; end
        vectors++;
        if (swi.seg7 !== seg_of(4'd0, 1'b0)) begin miscompares++; $display("FAIL lap_frozen_s10: got %h want %h", swi.seg7, seg_of(4'd0, 1'b0)); end
        press_btn(2);
        n = 0;
        while (swi.time_bcd !== 24'h000020 && n < 200) begin @(negedge clk0); n++; end
        while (swi.line !== 6'd2 && n < 240) begin @(negedge clk0); n++; end
        vectors++;
        if (swi.seg7 !== seg_of(4'd2, 1'b0)) begin miscompares++; $display("FAIL lap_live: got %h want %h", swi.seg7, seg_of(4'd2, 1'b0)); end
        press_btn(1);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_countdown();
        test_scan();
        test_clr_run();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
